// File: rtl/stage_writeback_if.sv
// Bus bundle between execute, data RAM, console and the writeback stage.
//   slave  : writeback stage view (takes the op/data, drives ack, RAM write, console)
//   master : environment view (execute + console side)
// Opcode bits (one-hot, all-zero = bubble):
//   0 INCDP, 1 DECDP, 2 INC, 3 DEC, 4 OUT, 5 IN, 6 LOOPBEGIN, 7 LOOPEND
interface stage_writeback_if #(
   parameter int unsigned A_WIDTH   = 12,
   parameter int unsigned D_WIDTH   = 8,
   parameter int unsigned OBUF_LOG2 = 2
);
   localparam int unsigned OP_W = 8;

   logic [OP_W-1:0]      operation_in;
   logic [D_WIDTH-1:0]   a;
   logic                 ack;
   logic [A_WIDTH-1:0]   dp;
   logic                 dwe;
   logic [A_WIDTH-1:0]   dwa;
   logic [D_WIDTH-1:0]   dwd;
   logic [7:0]           cq;
   logic                 cvalid;
   logic                 cready;
   logic [OBUF_LOG2:0]   obuf_level;
   logic                 idle;
   logic [31:0]          retired;

   modport slave (
      input  operation_in, a, dp, cready,
      output ack, dwe, dwa, dwd, cq, cvalid, obuf_level, idle, retired
   );

   modport master (
      output operation_in, a, dp, cready,
      input  ack, dwe, dwa, dwd, cq, cvalid, obuf_level, idle, retired
   );
endinterface

// File: rtl/stage_writeback.sv
// Final pipeline stage: commits INC/DEC/IN results to data RAM, queues OUT bytes
// in a small circular buffer drained to the console over valid/ready, provides
// the downstream ack for execute and counts retired instructions.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   wb (slave) : operation_in/a/dp from execute, ack back to execute,
//                dwe/dwa/dwd data RAM write, cq/cvalid/cready console,
//                obuf_level, idle, retired status
module stage_writeback #(
   parameter int unsigned A_WIDTH   = 12,
   parameter int unsigned D_WIDTH   = 8,
   parameter int unsigned OBUF_LOG2 = 2
) (
   input  logic               clk,
   input  logic               reset,
   stage_writeback_if.slave   wb
);
   localparam int unsigned OPCODE_MSB = 7;
   localparam int unsigned DEPTH      = 1 << OBUF_LOG2;
   localparam int unsigned LVL_W      = OBUF_LOG2 + 1;

   localparam logic [OPCODE_MSB:0] OP_INC = 8'b0000_0100;
   localparam logic [OPCODE_MSB:0] OP_DEC = 8'b0000_1000;
   localparam logic [OPCODE_MSB:0] OP_OUT = 8'b0001_0000;
   localparam logic [OPCODE_MSB:0] OP_IN  = 8'b0010_0000;

   logic [7:0]           mem_q [DEPTH];
   logic [7:0]           mem_d [DEPTH];
   logic [OBUF_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [OBUF_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]     level_q, level_d;
   logic [31:0]          retired_q, retired_d;

   logic                 write_op_c, out_op_c, full_c, cvalid_c, pop_c, push_c, ack_c;
   logic [7:0]           push_byte_c;

   // Opcode classification and handshake; only OUT into a full buffer stalls.
   always_comb begin
      write_op_c  = |(wb.operation_in & (OP_INC | OP_DEC | OP_IN));
      out_op_c    = |(wb.operation_in & OP_OUT);
      full_c      = (level_q == LVL_W'(DEPTH));
      cvalid_c    = (level_q != '0);
      pop_c       = cvalid_c && wb.cready;
      ack_c       = !(out_op_c && full_c && !pop_c);
      push_c      = ack_c && out_op_c;
      push_byte_c = 8'(wb.a);
   end

   // Next-state for buffer, pointers, occupancy and retire counter.
   always_comb begin
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      level_d   = level_q;
      retired_d = retired_q;

      if (push_c) begin
         mem_d[wr_ptr_q] = push_byte_c;
         wr_ptr_d        = wr_ptr_q + OBUF_LOG2'(1);
      end
      if (pop_c) begin
         rd_ptr_d = rd_ptr_q + OBUF_LOG2'(1);
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({push_c, pop_c})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase

      if (ack_c && (wb.operation_in != '0)) begin
         retired_d = retired_q + 32'd1;
      end
   end

   // State registers; reset clears contents too so cq reads 0 out of reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         retired_q <= '0;
      end else begin
         mem_q     <= mem_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         retired_q <= retired_d;
      end
   end

   // RAM write happens in the accepting cycle so execute sees it next cycle.
   assign wb.ack        = ack_c;
   assign wb.dwe        = ack_c && write_op_c;
   assign wb.dwa        = A_WIDTH'(wb.dp);
   assign wb.dwd        = D_WIDTH'(wb.a);
   assign wb.cq         = mem_q[rd_ptr_q];
   assign wb.cvalid     = cvalid_c;
   assign wb.obuf_level = level_q;
   assign wb.idle       = (level_q == '0) && (wb.operation_in == '0);
   assign wb.retired    = retired_q;
endmodule

// File: tb/tb_stage_writeback.sv
// Directed bench for stage_writeback with a byte scoreboard for console output.
module tb_stage_writeback;
   localparam logic [7:0] OP_NONE  = 8'h00;
   localparam logic [7:0] OP_INCDP = 8'h01;
   localparam logic [7:0] OP_INC   = 8'h04;
   localparam logic [7:0] OP_DEC   = 8'h08;
   localparam logic [7:0] OP_OUT   = 8'h10;
   localparam logic [7:0] OP_IN    = 8'h20;

   logic clk = 1'b0;
   logic reset;

   stage_writeback_if #(.A_WIDTH(12), .D_WIDTH(8), .OBUF_LOG2(2)) wb ();

   stage_writeback #(.A_WIDTH(12), .D_WIDTH(8), .OBUF_LOG2(2)) dut (
      .clk   (clk),
      .reset (reset),
      .wb    (wb.slave)
   );

   always #5 clk = ~clk;

   int          n_total  = 0;
   int          n_passed = 0;
   logic [7:0]  exp_q [$];
   logic [31:0] exp_retired = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_total++;
      assert (obs === exp_v) n_passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
   endtask

   // One cycle: drive, check against the model, update the model, advance.
   task automatic step(input logic [7:0] op, input logic [7:0] av,
                       input logic [11:0] dpv, input logic rdy);
      logic e_out, e_full, e_pop, e_ack, e_dwe;
      wb.operation_in = op;
      wb.a            = av;
      wb.dp           = dpv;
      wb.cready       = rdy;
      #1;
      e_out  = (op == OP_OUT);
      e_full = (exp_q.size() == 4);
      e_pop  = (exp_q.size() != 0) && rdy;
      e_ack  = !(e_out && e_full && !e_pop);
      e_dwe  = e_ack && (op == OP_INC || op == OP_DEC || op == OP_IN);
      chk("ack", 32'(wb.ack), 32'(e_ack));
      chk("dwe", 32'(wb.dwe), 32'(e_dwe));
      if (e_dwe) begin
         chk("dwa", 32'(wb.dwa), 32'(dpv));
         chk("dwd", 32'(wb.dwd), 32'(av));
      end
      chk("cvalid", 32'(wb.cvalid), 32'(exp_q.size() != 0));
      chk("obuf_level", 32'(wb.obuf_level), 32'(exp_q.size()));
      chk("idle", 32'(wb.idle), 32'((exp_q.size() == 0) && (op == OP_NONE)));
      chk("retired", wb.retired, exp_retired);
      if (exp_q.size() != 0) chk("cq", 32'(wb.cq), 32'(exp_q[0]));
      if (e_pop) void'(exp_q.pop_front());
      if (e_ack && e_out) exp_q.push_back(av);
      if (e_ack && op != OP_NONE) exp_retired++;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic rdy);
      reset           = 1'b1;
      wb.operation_in = OP_NONE;
      wb.a            = '0;
      wb.dp           = '0;
      wb.cready       = rdy;
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_q.delete();
      exp_retired = 0;
   endtask

   initial begin
      reset           = 1'b1;
      wb.operation_in = OP_NONE;
      wb.a            = '0;
      wb.dp           = '0;
      wb.cready       = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      do_reset(1'b0);

      // 1: reset state and bubbles
      #1;
      chk("reset_cq", 32'(wb.cq), 32'h0);
      repeat (3) step(OP_NONE, 8'h00, 12'h000, 1'b0);

      // 2: INC commit, then a plain DP op retiring without side effect
      step(OP_INC, 8'h42, 12'h005, 1'b0);
      step(OP_INCDP, 8'h42, 12'h005, 1'b0);
      step(OP_NONE, 8'h00, 12'h006, 1'b0);

      // 3: fill the buffer, stall 5th OUT, release with one-cycle cready
      step(OP_OUT, 8'h48, 12'h006, 1'b0);
      step(OP_OUT, 8'h69, 12'h006, 1'b0);
      step(OP_OUT, 8'h21, 12'h006, 1'b0);
      step(OP_OUT, 8'h0A, 12'h006, 1'b0);
      step(OP_OUT, 8'h33, 12'h006, 1'b0);
      step(OP_OUT, 8'h33, 12'h006, 1'b0);
      step(OP_OUT, 8'h33, 12'h006, 1'b1);

      // 4: drain with toggling cready, one more OUT mid-drain (6 pushes total)
      step(OP_NONE, 8'h00, 12'h006, 1'b1);
      step(OP_NONE, 8'h00, 12'h006, 1'b0);
      step(OP_OUT, 8'hC3, 12'h006, 1'b1);
      step(OP_NONE, 8'h00, 12'h006, 1'b0);
      for (int i = 0; i < 8; i++) step(OP_NONE, 8'h00, 12'h006, (i % 2) == 0);
      chk("drained", 32'(wb.obuf_level), 32'h0);

      // 5: IN never stalls even with a full buffer
      step(OP_OUT, 8'h01, 12'h006, 1'b0);
      step(OP_OUT, 8'h02, 12'h006, 1'b0);
      step(OP_OUT, 8'h03, 12'h006, 1'b0);
      step(OP_OUT, 8'h04, 12'h006, 1'b0);
      step(OP_IN, 8'h7F, 12'h123, 1'b0);
      step(OP_DEC, 8'hFE, 12'hFFF, 1'b0);

      // 6: three bytes buffered, reset mid-transfer, then a fresh OUT
      step(OP_NONE, 8'h00, 12'h006, 1'b1);
      do_reset(1'b1);
      step(OP_NONE, 8'h00, 12'h000, 1'b0);
      step(OP_OUT, 8'h55, 12'h000, 1'b0);
      step(OP_NONE, 8'h00, 12'h000, 1'b0);
      step(OP_NONE, 8'h00, 12'h000, 1'b1);
      step(OP_NONE, 8'h00, 12'h000, 1'b1);

      $display("%0d/%0d checks passed", n_passed, n_total);
      $finish;
   end
endmodule
